// File: rtl/uart_rgb_rx.sv
// UART 8N1 receiver that packs R,G,B byte triplets into 24-bit pixels,
// with a per-frame pixel counter and a byte-gap timeout.
module uart_rgb_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  output logic [23:0] pix_rgb,
  output logic        pix_valid,
  output logic        frame_done,
  output logic        rx_err
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam int TMO     = 16 * BPS_CNT;
  localparam int CW      = $clog2(BPS_CNT + 1);
  localparam int PW      = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TW      = $clog2(TMO + 1);

  localparam logic [CW-1:0] HALF_C = CW'(BPS_CNT / 2);
  localparam logic [CW-1:0] FULL_C = CW'(BPS_CNT - 1);
  localparam logic [PW-1:0] LAST_C = PW'(NPIX - 1);
  localparam logic [TW-1:0] TMO_C  = TW'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    r_q, r_d;
  logic [7:0]    g_q, g_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [23:0]   pix_rgb_q;
  logic          pix_valid_q, frame_done_q, rx_err_q;

  logic fall, accept, ferr, tmo_fire, pix_done, pix_last;

  assign fall = rx_s3_q & ~rx_s2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    accept  = 1'b0;
    ferr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_C) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_C) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_C) begin
          cnt_d   = '0;
          state_d = IDLE;
          accept  = rx_s2_q;
          ferr    = ~rx_s2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Gap timer only runs while a pixel is partially assembled and the line is idle.
  assign tmo_fire = (phase_q != 2'd0) && (state_q == IDLE) && (tmo_q == TMO_C);
  assign pix_done = accept && (phase_q == 2'd2);
  assign pix_last = (pix_cnt_q == LAST_C);

  always_comb begin
    phase_d   = phase_q;
    r_d       = r_q;
    g_d       = g_q;
    pix_cnt_d = pix_cnt_q;
    tmo_d     = tmo_q;
    if (accept || state_q != IDLE || phase_q == 2'd0 || tmo_fire)
      tmo_d = '0;
    else
      tmo_d = tmo_q + TW'(1);
    if (ferr || tmo_fire) begin
      phase_d = 2'd0;
    end else if (accept) begin
      unique case (1'b1)
        (phase_q == 2'd0): begin
          r_d     = sh_q;
          phase_d = 2'd1;
        end
        (phase_q == 2'd1): begin
          g_d     = sh_q;
          phase_d = 2'd2;
        end
        default: phase_d = 2'd0;
      endcase
    end
    if (pix_done)
      pix_cnt_d = pix_last ? '0 : pix_cnt_q + PW'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      phase_q      <= '0;
      r_q          <= '0;
      g_q          <= '0;
      pix_cnt_q    <= '0;
      tmo_q        <= '0;
      pix_rgb_q    <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      rx_s1_q      <= uart_rxd;
      rx_s2_q      <= rx_s1_q;
      rx_s3_q      <= rx_s2_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      phase_q      <= phase_d;
      r_q          <= r_d;
      g_q          <= g_d;
      pix_cnt_q    <= pix_cnt_d;
      tmo_q        <= tmo_d;
      pix_valid_q  <= pix_done;
      frame_done_q <= pix_done && pix_last;
      rx_err_q     <= ferr || tmo_fire;
      if (pix_done) pix_rgb_q <= {r_q, g_q, sh_q};
    end
  end

  assign pix_rgb    = pix_rgb_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign rx_err     = rx_err_q;

endmodule

// File: tb/tb_uart_rgb_rx.sv
// Bench for uart_rgb_rx: serial byte driver, pixel scoreboard,
// framing/timeout/glitch/reset scenarios.
module tb_uart_rgb_rx;

  localparam int CLK_FREQ = 1600000;
  localparam int UART_BPS = 100000;
  localparam int BPS      = CLK_FREQ / UART_BPS;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 2;
  localparam int NPIX     = IMG_W * IMG_H;

  typedef struct packed {
    logic [23:0] rgb;
    logic        fd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic [23:0] pix_rgb;
  logic        pix_valid;
  logic        frame_done;
  logic        rx_err;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   err_cnt;
  int   pix_seen;
  int   cyc;
  int   last_err_cyc;
  int   last_stop_c;
  int   model_cnt;

  uart_rgb_rx #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS),
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .uart_rxd  (rxd),
    .pix_rgb   (pix_rgb),
    .pix_valid (pix_valid),
    .frame_done(frame_done),
    .rx_err    (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pix_valid pops one expected pixel.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_err) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (frame_done && !pix_valid) begin
        n_checks++;
        n_fail++;
        $display("FAIL fd_strobe: frame_done=1 without pix_valid at cyc %0d", cyc);
      end
      if (pix_valid) begin
        exp_t e;
        n_checks++;
        pix_seen++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pix: got %h fd=%b, none expected", pix_rgb, frame_done);
        end else begin
          e = exp_q.pop_front();
          if (pix_rgb !== e.rgb || frame_done !== e.fd) begin
            n_fail++;
            $display("FAIL pix: got %h fd=%b, expected %h fd=%b",
                     pix_rgb, frame_done, e.rgb, e.fd);
          end
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BPS) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int nbits);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(b[i]);
    if (nbits == 8) begin
      last_stop_c = cyc;
      drive_bit(stop_ok);
      drive_bit(1'b1);
      drive_bit(1'b1);
    end
  endtask

  task automatic send_pixel(input logic [23:0] rgb);
    exp_t e;
    e.rgb = rgb;
    e.fd  = (model_cnt == NPIX - 1);
    model_cnt = (model_cnt == NPIX - 1) ? 0 : model_cnt + 1;
    exp_q.push_back(e);
    send_byte(rgb[23:16], 1'b1, 8);
    send_byte(rgb[15:8], 1'b1, 8);
    send_byte(rgb[7:0], 1'b1, 8);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    model_cnt = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (pix_rgb !== 24'h0 || pix_valid !== 1'b0 ||
        frame_done !== 1'b0 || rx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: rgb=%h v=%b fd=%b err=%b, expected all 0",
               pix_rgb, pix_valid, frame_done, rx_err);
    end
    n_checks++;
    if (dut.state_q !== 2'd0 || dut.phase_q !== 2'd0 ||
        dut.pix_cnt_q !== 3'd0 || dut.tmo_q !== '0) begin
      n_fail++;
      $display("FAIL reset_state: st=%0d ph=%0d pc=%0d tmo=%0d, expected 0",
               dut.state_q, dut.phase_q, dut.pix_cnt_q, dut.tmo_q);
    end
    n_checks++;
    if ({dut.rx_s1_q, dut.rx_s2_q, dut.rx_s3_q} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_sync: got %b, expected 111",
               {dut.rx_s1_q, dut.rx_s2_q, dut.rx_s3_q});
    end
    rst_n = 1'b1;
    model_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (pix_valid !== 1'b0 || rx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_out: v=%b err=%b, expected 0 0", pix_valid, rx_err);
    end
  endtask

  task automatic test_basic();
    int e0 = err_cnt;
    send_pixel(24'h123456);
    n_checks++;
    if (pix_rgb !== 24'h123456 || err_cnt != e0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic: rgb=%h errs=%0d pend=%0d, expected 123456 0 0",
               pix_rgb, err_cnt - e0, exp_q.size());
    end
  endtask

  task automatic test_frame();
    int p0;
    apply_reset();
    p0 = pix_seen;
    for (int i = 0; i < NPIX + 1; i++)
      send_pixel({8'(i), 8'(i + 8'h40), 8'(8'hF0 - i)});
    n_checks++;
    if (pix_seen - p0 != NPIX + 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_count: pix=%0d pend=%0d, expected %0d 0",
               pix_seen - p0, exp_q.size(), NPIX + 1);
    end
    n_checks++;
    if (dut.pix_cnt_q !== 3'd1) begin
      n_fail++;
      $display("FAIL frame_wrap: pix_cnt=%0d, expected 1", dut.pix_cnt_q);
    end
  endtask

  task automatic test_framing();
    int e0 = err_cnt;
    int p0 = pix_seen;
    send_byte(8'hAA, 1'b0, 8);
    n_checks++;
    if (err_cnt - e0 != 1 || pix_seen != p0) begin
      n_fail++;
      $display("FAIL framing_err: errs=%0d pix=%0d, expected 1 0",
               err_cnt - e0, pix_seen - p0);
    end
    n_checks++;
    if (dut.phase_q !== 2'd0) begin
      n_fail++;
      $display("FAIL framing_phase: phase=%0d, expected 0", dut.phase_q);
    end
    send_pixel(24'h010203);
    n_checks++;
    if (pix_rgb !== 24'h010203 || err_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL framing_after: rgb=%h errs=%0d, expected 010203 1",
               pix_rgb, err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    int d;
    send_byte(8'hFF, 1'b1, 8);
    send_byte(8'hEE, 1'b1, 8);
    repeat (20) drive_bit(1'b1);
    d = last_err_cyc - last_stop_c;
    n_checks++;
    if (err_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL tmo_count: errs=%0d, expected 1", err_cnt - e0);
    end
    n_checks++;
    if (d < 12 + 16 * BPS - 2 || d > 12 + 16 * BPS + 2) begin
      n_fail++;
      $display("FAIL tmo_time: err %0d cyc after stop drive, expected %0d",
               d, 12 + 16 * BPS);
    end
    send_pixel(24'h0A0B0C);
    n_checks++;
    if (pix_rgb !== 24'h0A0B0C || err_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL tmo_after: rgb=%h errs=%0d, expected 0a0b0c 1",
               pix_rgb, err_cnt - e0);
    end
  endtask

  task automatic test_glitch();
    int e0 = err_cnt;
    int p0 = pix_seen;
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut.state_q !== 2'd1) begin
      n_fail++;
      $display("FAIL glitch_start: state=%0d, expected 1", dut.state_q);
    end
    repeat (2 * BPS) @(posedge clk);
    #1;
    n_checks++;
    if (dut.state_q !== 2'd0 || err_cnt != e0 || pix_seen != p0) begin
      n_fail++;
      $display("FAIL glitch: state=%0d errs=%0d pix=%0d, expected 0 0 0",
               dut.state_q, err_cnt - e0, pix_seen - p0);
    end
    send_pixel(24'hC0FFEE);
    n_checks++;
    if (pix_rgb !== 24'hC0FFEE) begin
      n_fail++;
      $display("FAIL glitch_after: rgb=%h, expected c0ffee", pix_rgb);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h99, 1'b1, 8);
    send_byte(8'h77, 1'b1, 3);
    apply_reset();
    send_pixel(24'h112233);
    n_checks++;
    if (pix_rgb !== 24'h112233 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_pix: rgb=%h pend=%0d, expected 112233 0",
               pix_rgb, exp_q.size());
    end
    n_checks++;
    if (dut.pix_cnt_q !== 3'd1) begin
      n_fail++;
      $display("FAIL rst_mid_cnt: pix_cnt=%0d, expected 1", dut.pix_cnt_q);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    err_cnt   = 0;
    pix_seen  = 0;
    model_cnt = 0;
    last_err_cyc = 0;
    last_stop_c  = 0;
    rst_n = 1'b1;
    rxd   = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_frame();
    test_framing();
    test_timeout();
    test_glitch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rgb_rx.md
UART_RGB_RX -- requirements
Module: uart_rgb_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter UART_BPS, default 115200, serial baud rate.
REQ-003 The block SHALL have parameter IMG_W, default 640, pixels per line.
REQ-004 The block SHALL have parameter IMG_H, default 480, lines per frame.
REQ-005 The block SHALL have port sys_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port uart_rxd, input, 1, asynchronous UART serial input, idle high.
REQ-008 The block SHALL have port pix_rgb, output, 24, assembled pixel: [23:16]=R, [15:8]=G, [7:0]=B.
REQ-009 The block SHALL have port pix_valid, output, 1, one-cycle strobe qualifying pix_rgb.
REQ-010 The block SHALL have port frame_done, output, 1, one-cycle strobe coincident with pix_valid of the last pixel of a frame.
REQ-011 The block SHALL have port rx_err, output, 1, one-cycle strobe on framing error or pixel-assembly timeout.

Function
REQ-012 The block SHALL define BPS_CNT = CLK_FREQ/UART_BPS (integer division); 434 at defaults.
REQ-013 The block SHALL pass uart_rxd through a 2-flop synchronizer, then detect a falling edge with a third flop.
REQ-014 The byte receiver SHALL use states IDLE, START, DATA, STOP.
REQ-015 In IDLE, a synchronized falling edge SHALL move to START and clear the baud counter.
REQ-016 In START at count BPS_CNT/2, the block SHALL sample the line. High → return to IDLE as a glitch, with no rx_err. Low → go to DATA and restart bit timing.
REQ-017 DATA SHALL sample 8 bits LSB-first, each at the mid-point of its bit period (every BPS_CNT cycles after the start mid-point).
REQ-018 STOP SHALL sample at the stop-bit mid-point. High → byte accepted. Low → byte discarded, rx_err pulsed, byte phase reset to 0. In both cases return to IDLE.
REQ-019 Accepted bytes SHALL be assigned in order R, G, B using a 2-bit byte phase 0→1→2→0.
REQ-020 On acceptance of the phase-2 byte, the block SHALL update pix_rgb and assert pix_valid for exactly one cycle, on the cycle after the stop-bit sample.
REQ-021 pix_rgb SHALL hold its value until the next completed pixel.
REQ-022 A pixel counter SHALL count 0..IMG_W*IMG_H-1, incrementing on each pix_valid.
REQ-023 On the pixel where the counter equals IMG_W*IMG_H-1, frame_done SHALL assert with that pix_valid and the counter SHALL wrap to 0 in the same cycle.
REQ-024 Timeout: if the byte phase is nonzero and no start bit arrives within 16*BPS_CNT cycles of the last accepted byte, the block SHALL reset the byte phase to 0 and pulse rx_err once; the pixel counter is unaffected.
REQ-025 If a framing error and a timeout fall on the same cycle, rx_err SHALL be a single one-cycle pulse.
REQ-026 A start edge arriving while not in IDLE SHALL be ignored.
REQ-027 The block SHALL not support backpressure; the consumer accepts every pix_valid.

Reset
REQ-028 While sys_rst_n is low, the block SHALL hold pix_rgb=0, pix_valid=0, frame_done=0, rx_err=0, FSM=IDLE, byte phase=0, pixel counter=0, timeout counter=0, and synchronizer flops=1.
REQ-029 Reset asserted mid-byte or mid-pixel SHALL discard all partial data; after release, the first accepted byte SHALL be R.

Verification
REQ-030 With defaults, send bytes 0x12,0x34,0x56 at 115200 8N1 → one pix_valid with pix_rgb=0x123456, no rx_err.
REQ-031 With IMG_W=4, IMG_H=2, send 8 pixels → 8 pix_valid pulses, frame_done only on the 8th; a 9th pixel → counter restarts, no frame_done.
REQ-032 Send 0xAA with the stop bit driven low → no byte accepted, one rx_err pulse; then send 0x01,0x02,0x03 → pix_rgb=0x010203.
REQ-033 Send 0xFF,0xEE, then idle 20 bit times → one rx_err at 16*BPS_CNT cycles after the second stop sample; then send 0x0A,0x0B,0x0C → pix_rgb=0x0A0B0C.
REQ-034 Drive a 100-cycle low glitch on uart_rxd → no byte, no rx_err, FSM back in IDLE.
REQ-035 Assert sys_rst_n low during the G byte of a pixel, release, then send 0x11,0x22,0x33 → pix_rgb=0x112233 and pixel counter=1.
